// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: helpers shared by the adder tree and the FC datapath.
//   clog2        - ceiling log2, used for the tree depth
//   lanes_at     - number of lanes left after a given number of pairwise levels
//   level_width  - lane width at a given tree level (full precision, +1 bit per level)
//   sat_relu     - optional ReLU followed by clamping to a signed data width
package adder_tree_pkg;

  // Working width of sat_relu; callers sign-extend into it and slice the result.
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned lanes_at(input int unsigned n, input int unsigned lvl);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      r = (r + 1) / 2;
    end
    return r;
  endfunction

  function automatic int unsigned level_width(input int unsigned dw, input int unsigned lvl);
    return dw + lvl;
  endfunction

  // ReLU (when enabled) then clamp to [-2^(dw-1), 2^(dw-1)-1].
  // sat reports whether the clamp changed the value; ReLU alone never sets it.
  function automatic sat_res_t sat_relu(input logic signed [SAT_W-1:0] r,
                                        input int unsigned            dw,
                                        input logic                   relu);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    one = 1;
    hi  = (one <<< (dw - 1)) - one;
    lo  = ~hi;
    v   = (relu && r[SAT_W-1]) ? '0 : r;
    res.sat = 1'b0;
    res.val = v;
    if (v > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (v < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered pairwise-reduction level of the adder tree.
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_i/first_i/last_i/bias_i  sideband, delayed one cycle in lock-step
//   data_i             N_IN packed signed lanes of W_IN bits, lane 0 at LSBs
//   *_o                registered sideband and N_OUT = ceil(N_IN/2) lanes of W_IN+1 bits
module adder_tree_level #(
  parameter int unsigned N_IN   = 6,
  parameter int unsigned W_IN   = 16,
  parameter int unsigned BIAS_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_i,
  input  logic                                  first_i,
  input  logic                                  last_i,
  input  logic [BIAS_W-1:0]                     bias_i,
  input  logic [N_IN*W_IN-1:0]                  data_i,
  output logic                                  valid_o,
  output logic                                  first_o,
  output logic                                  last_o,
  output logic [BIAS_W-1:0]                     bias_o,
  output logic [((N_IN+1)/2)*(W_IN+1)-1:0]      data_o
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;
  localparam int unsigned W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] sum_d;
  logic [N_OUT*W_OUT-1:0] data_q;
  logic                   valid_q;
  logic                   first_q;
  logic                   last_q;
  logic [BIAS_W-1:0]      bias_q;

  for (genvar p = 0; p < N_IN / 2; p++) begin : g_pair
    logic [W_IN-1:0] a;
    logic [W_IN-1:0] b;
    assign a = data_i[(2*p)*W_IN +: W_IN];
    assign b = data_i[(2*p+1)*W_IN +: W_IN];
    // One extra bit per level keeps the pair sum exact.
    assign sum_d[p*W_OUT +: W_OUT] = {a[W_IN-1], a} + {b[W_IN-1], b};
  end

  if (N_IN % 2 == 1) begin : g_odd
    assign sum_d[(N_OUT-1)*W_OUT +: W_OUT] =
      {data_i[N_IN*W_IN-1], data_i[(N_IN-1)*W_IN +: W_IN]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      bias_q  <= '0;
    end else begin
      data_q  <= sum_d;
      valid_q <= valid_i;
      first_q <= first_i;
      last_q  <= last_i;
      bias_q  <= bias_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign bias_o  = bias_q;

endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined NUM_IN-lane signed adder tree with multi-beat
// accumulation, bias add, optional ReLU and output saturation.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     beat qualifier; in_first / in_last mark group boundaries
//   in_data      NUM_IN packed signed lanes of DATA_WIDTH, lane 0 at LSBs
//   bias         signed bias, used only on a valid in_first beat
//   relu_en      quasi-static ReLU enable
//   out_valid    one-cycle pulse per completed group
//   out_data     clamped signed result, held between pulses
//   out_sat      result was clamped, held between pulses
// Stages: input register (0), tree levels 1..D, accumulate (D+1), output (D+2).
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 6,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [DATA_WIDTH-1:0]        bias,
  input  logic                         relu_en,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sat
);

  localparam int unsigned D     = clog2(NUM_IN);
  localparam int unsigned SUM_W = level_width(DATA_WIDTH, D);

  // Stage 0: input capture.
  logic [NUM_IN*DATA_WIDTH-1:0] in_data_q;
  logic                         in_valid_q;
  logic                         in_first_q;
  logic                         in_last_q;
  logic [DATA_WIDTH-1:0]        in_bias_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      in_first_q <= 1'b0;
      in_last_q  <= 1'b0;
      in_bias_q  <= '0;
    end else begin
      in_data_q  <= in_data;
      in_valid_q <= in_valid;
      in_first_q <= in_first;
      in_last_q  <= in_last;
      in_bias_q  <= bias;
    end
  end

  // Stages 1..D: reduction levels, each chained to the previous block's outputs.
  for (genvar k = 0; k < D; k++) begin : g_lvl
    localparam int unsigned NI = lanes_at(NUM_IN, k);
    localparam int unsigned WI = level_width(DATA_WIDTH, k);
    localparam int unsigned NO = lanes_at(NUM_IN, k + 1);
    localparam int unsigned WO = WI + 1;

    logic [NI*WI-1:0]      din;
    logic                  vin;
    logic                  fin;
    logic                  lin;
    logic [DATA_WIDTH-1:0] bin;
    logic [NO*WO-1:0]      dout;
    logic                  vout;
    logic                  fout;
    logic                  lout;
    logic [DATA_WIDTH-1:0] bout;

    if (k == 0) begin : g_src
      assign din = in_data_q;
      assign vin = in_valid_q;
      assign fin = in_first_q;
      assign lin = in_last_q;
      assign bin = in_bias_q;
    end else begin : g_chain
      assign din = g_lvl[k-1].dout;
      assign vin = g_lvl[k-1].vout;
      assign fin = g_lvl[k-1].fout;
      assign lin = g_lvl[k-1].lout;
      assign bin = g_lvl[k-1].bout;
    end

    adder_tree_level #(
      .N_IN   (NI),
      .W_IN   (WI),
      .BIAS_W (DATA_WIDTH)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (vin),
      .first_i (fin),
      .last_i  (lin),
      .bias_i  (bin),
      .data_i  (din),
      .valid_o (vout),
      .first_o (fout),
      .last_o  (lout),
      .bias_o  (bout),
      .data_o  (dout)
    );
  end

  logic [SUM_W-1:0]      tree_sum;
  logic                  tree_valid;
  logic                  tree_first;
  logic                  tree_last;
  logic [DATA_WIDTH-1:0] tree_bias;

  assign tree_sum   = g_lvl[D-1].dout;
  assign tree_valid = g_lvl[D-1].vout;
  assign tree_first = g_lvl[D-1].fout;
  assign tree_last  = g_lvl[D-1].lout;
  assign tree_bias  = g_lvl[D-1].bout;

  // Stage D+1: accumulate.
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 open_q, open_d;
  logic                 acc_last_q, acc_last_d;
  logic [ACC_WIDTH-1:0] sum_ext;
  logic [ACC_WIDTH-1:0] bias_ext;
  logic [ACC_WIDTH-1:0] base;

  assign sum_ext  = {{(ACC_WIDTH-SUM_W){tree_sum[SUM_W-1]}}, tree_sum};
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){tree_bias[DATA_WIDTH-1]}}, tree_bias};

  always_comb begin
    base       = '0;
    acc_d      = acc_q;
    open_d     = open_q;
    acc_last_d = 1'b0;
    // A headless beat starts from zero; a new first discards any open sum.
    if (tree_first) begin
      base = bias_ext;
    end else if (open_q) begin
      base = acc_q;
    end
    if (tree_valid) begin
      acc_d      = base + sum_ext;
      open_d     = !tree_last;
      acc_last_d = tree_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      open_q     <= 1'b0;
      acc_last_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      open_q     <= open_d;
      acc_last_q <= acc_last_d;
    end
  end

  // Stage D+2: ReLU, clamp, output register.
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;
  logic                  out_valid_q, out_valid_d;
  logic [SAT_W-1:0]      acc_wide;
  sat_res_t              res;

  assign acc_wide = {{(SAT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
  assign res      = sat_relu(acc_wide, DATA_WIDTH, relu_en);

  always_comb begin
    out_valid_d = acc_last_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (acc_last_q) begin
      out_data_d = res.val[DATA_WIDTH-1:0];
      out_sat_d  = res.sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc at default parameters (6 lanes x 16 bit, latency 5).
module tb_adder_tree_acc;

  localparam int DW  = 16;
  localparam int NI  = 6;
  localparam int AW  = 32;
  localparam int LAT = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [NI*DW-1:0]     in_data;
  logic                 in_first;
  logic                 in_last;
  logic [DW-1:0]        bias;
  logic                 relu_en;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_sat;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 s;
    int                   at;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic signed [DW-1:0] lane;
    logic                 seq;
    logic signed [DW-1:0] b;
    logic                 relu;
    logic signed [DW-1:0] ed;
    logic                 es;
  } vec_t;

  vec_t vecs[10];

  adder_tree_acc #(
    .DATA_WIDTH (DW),
    .NUM_IN     (NI),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NI*DW-1:0] lanes_all(input logic signed [DW-1:0] v);
    logic [NI*DW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NI*DW-1:0] lanes_seq();
    logic [NI*DW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = DW'(i + 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expected group.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && out_valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got out_valid=%b data=%0d, expected no output (t=%0t)",
                 out_valid, $signed(out_data), $time);
      end else begin
        e = sbq.pop_front();
        chk("out_data", $signed(out_data), e.d);
        chk("out_sat", {31'd0, out_sat}, {31'd0, e.s});
        chk("out_cycle", cyc, e.at);
      end
    end
  end

  task automatic beat(input logic [NI*DW-1:0] d, input logic f, input logic l,
                      input logic [DW-1:0] b, input bit push,
                      input logic signed [DW-1:0] ed, input logic es);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    bias     = b;
    if (push) sbq.push_back('{ed, es, cyc + LAT + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = $urandom_range(0, 1);
      in_last  = $urandom_range(0, 1);
      in_data  = {$urandom, $urandom, $urandom};
      bias     = DW'($urandom);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sbq.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outputs pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    bias     = '0;
    relu_en  = 1'b0;

    vecs[0] = '{16'sd0,      1'b1, 16'sd10,     1'b0, 16'sd31,     1'b0};
    vecs[1] = '{16'sd32767,  1'b0, 16'sd0,      1'b0, 16'sd32767,  1'b1};
    vecs[2] = '{-16'sd32768, 1'b0, 16'sd0,      1'b0, -16'sd32768, 1'b1};
    vecs[3] = '{-16'sd32768, 1'b0, 16'sd0,      1'b1, 16'sd0,      1'b0};
    vecs[4] = '{-16'sd5,     1'b0, 16'sd3,      1'b1, 16'sd0,      1'b0};
    vecs[5] = '{-16'sd5,     1'b0, 16'sd3,      1'b0, -16'sd27,    1'b0};
    vecs[6] = '{16'sd5461,   1'b0, 16'sd1,      1'b0, 16'sd32767,  1'b0};
    vecs[7] = '{16'sd5461,   1'b0, 16'sd2,      1'b0, 16'sd32767,  1'b1};
    vecs[8] = '{-16'sd5461,  1'b0, -16'sd2,     1'b0, -16'sd32768, 1'b0};
    vecs[9] = '{-16'sd1,     1'b0, -16'sd32768, 1'b0, -16'sd32768, 1'b1};

    #23;
    chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("rst_out_data", $signed(out_data), 32'sd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'sd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Single-beat groups from the table; relu_en only changes with the pipe empty.
    foreach (vecs[i]) begin
      drain();
      idle(1);
      relu_en = vecs[i].relu;
      beat(vecs[i].seq ? lanes_seq() : lanes_all(vecs[i].lane), 1'b1, 1'b1,
           vecs[i].b, 1'b1, vecs[i].ed, vecs[i].es);
      idle(1);
    end
    drain();
    idle(1);
    relu_en = 1'b0;

    // Three-beat group with bubbles: 3*600 - 50.
    beat(lanes_all(16'sd100), 1'b1, 1'b0, -16'sd50, 1'b0, 16'sd0, 1'b0);
    idle(2);
    beat(lanes_all(16'sd100), 1'b0, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b0);
    idle(2);
    beat(lanes_all(16'sd100), 1'b0, 1'b1, 16'sd0, 1'b1, 16'sd1750, 1'b0);
    idle(1);
    drain();

    // Back-to-back single-beat groups.
    for (int i = 1; i <= 20; i++) begin
      beat(lanes_all(DW'(i)), 1'b1, 1'b1, 16'sd0, 1'b1, DW'(6 * i), 1'b0);
    end
    idle(1);
    drain();

    // A new first beat discards an open partial sum.
    beat(lanes_all(16'sd50), 1'b1, 1'b0, 16'sd7, 1'b0, 16'sd0, 1'b0);
    beat(lanes_seq(), 1'b1, 1'b1, 16'sd0, 1'b1, 16'sd21, 1'b0);
    idle(1);
    drain();

    // Headless beat: bias ignored, base 0.
    beat(lanes_all(16'sd2), 1'b0, 1'b1, 16'sd99, 1'b1, 16'sd12, 1'b0);
    idle(1);
    drain();

    // Reset mid-group kills an in-flight group and the open partial sum.
    beat(lanes_all(16'sd7), 1'b1, 1'b1, 16'sd0, 1'b0, 16'sd0, 1'b0);
    beat(lanes_all(16'sd3), 1'b1, 1'b0, 16'sd5, 1'b0, 16'sd0, 1'b0);
    beat(lanes_all(16'sd3), 1'b0, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("midrst_out_data", $signed(out_data), 32'sd0);
    chk("midrst_out_sat", {31'd0, out_sat}, 32'sd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    beat(lanes_all(16'sd1), 1'b0, 1'b1, 16'sd0, 1'b1, 16'sd6, 1'b0);
    idle(1);
    drain();

    idle(10);
    chk("scoreboard_empty", sbq.size(), 32'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
